// File: rtl/bus_arbiter.sv
// bus_arbiter: round-robin arbiter for the shared tiny16 bus.
// The grant is registered and one-hot. A dead GAP cycle separates every change
// of owner. A contended unlocked owner is preempted after MAX_HOLD cycles. A
// locked owner is force-released after LOCK_LIMIT cycles, which pulses
// timeout and sets the sticky err flag.
module bus_arbiter #(
  parameter int NREQ       = 4,
  parameter int MAX_HOLD   = 4,
  parameter int LOCK_LIMIT = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  input  logic [NREQ-1:0] lock,
  output logic [NREQ-1:0] gnt,
  output logic [2:0]      owner,
  output logic            busy,
  output logic            timeout,
  output logic            err
);

  localparam int CW = $clog2(LOCK_LIMIT);

  typedef enum logic [1:0] {S_IDLE, S_GRANT, S_GAP} state_t;

  state_t          r_state;
  logic [NREQ-1:0] r_gnt;
  logic [2:0]      r_owner;
  logic [2:0]      r_last;
  logic [CW-1:0]   r_hold;
  logic            r_timeout;
  logic            r_err;

  // Widened to 8 bits so a 3-bit owner index always selects a valid bit.
  logic [7:0]      w_req8;
  logic [7:0]      w_lock8;
  logic            w_other;
  logic            w_found;
  logic [2:0]      w_win;
  int              w_sum;

  assign w_req8  = 8'(req);
  assign w_lock8 = 8'(lock);
  // Any request other than the current owner's; only meaningful in GRANT.
  assign w_other = |(w_req8 & ~(8'd1 << r_last));

  // Round-robin search starting just after the last owner and ending on it.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_sum   = 0;
    for (int i = 1; i <= NREQ; i++) begin
      w_sum = (int'(r_last) + i) % NREQ;
      if (!w_found && w_req8[3'(w_sum)]) begin
        w_found = 1'b1;
        w_win   = 3'(w_sum);
      end
    end
  end

  // Arbiter state machine with registered grant, owner and status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_gnt     <= '0;
      r_owner   <= '0;
      r_last    <= 3'(NREQ-1);
      r_hold    <= '0;
      r_timeout <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_timeout <= 1'b0;
      case (r_state)
        S_IDLE, S_GAP: begin
          if (w_found) begin
            r_state <= S_GRANT;
            r_gnt   <= NREQ'(1) << w_win;
            r_owner <= w_win;
            r_last  <= w_win;
            r_hold  <= '0;
          end else begin
            r_state <= S_IDLE;
            r_gnt   <= '0;
            r_owner <= '0;
          end
        end
        S_GRANT: begin
          if (!w_req8[r_last]) begin
            r_state <= S_GAP;
            r_gnt   <= '0;
            r_owner <= '0;
          end else if (w_lock8[r_last] && r_hold == CW'(LOCK_LIMIT-1)) begin
            // Lock held too long: force release and flag it.
            r_state   <= S_GAP;
            r_gnt     <= '0;
            r_owner   <= '0;
            r_timeout <= 1'b1;
            r_err     <= 1'b1;
          end else if (!w_lock8[r_last] && r_hold >= CW'(MAX_HOLD-1) && w_other) begin
            r_state <= S_GAP;
            r_gnt   <= '0;
            r_owner <= '0;
          end else if (w_lock8[r_last] || r_hold < CW'(MAX_HOLD-1)) begin
            // Unlocked tenure saturates at MAX_HOLD-1; locked keeps counting.
            r_hold <= r_hold + CW'(1);
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_gnt   <= '0;
          r_owner <= '0;
        end
      endcase
    end
  end

  assign gnt     = r_gnt;
  assign owner   = r_owner;
  assign busy    = |r_gnt;
  assign timeout = r_timeout;
  assign err     = r_err;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter (NREQ=4, MAX_HOLD=4, LOCK_LIMIT=16).
module tb_bus_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req = '0;
  logic [3:0] lock = '0;
  logic [3:0] gnt;
  logic [2:0] owner;
  logic       busy, timeout, err;

  int total = 0;
  int bad   = 0;

  bus_arbiter #(.NREQ(4), .MAX_HOLD(4), .LOCK_LIMIT(16)) dut (
    .clk(clk), .rst(rst), .req(req), .lock(lock),
    .gnt(gnt), .owner(owner), .busy(busy), .timeout(timeout), .err(err)
  );

  always #5 clk = ~clk;

  // Advance one cycle; outputs of that edge are stable afterwards.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; req = '0; lock = '0;
    step();
    rst = 1'b0;
  endtask

  // Grant safety: never multi-hot, never two different owners back to back.
  logic [3:0] prev_gnt = '0;
  always @(negedge clk) begin
    if (!rst) begin
      total++;
      if ((gnt & (gnt - 4'd1)) != 4'd0) begin
        bad++;
        $display("FAIL onehot gnt=%b required at most one bit", gnt);
      end
      total++;
      if (prev_gnt != 4'd0 && gnt != 4'd0 && prev_gnt !== gnt) begin
        bad++;
        $display("FAIL no_gap prev=%b gnt=%b required a zero cycle between", prev_gnt, gnt);
      end
    end
    prev_gnt = gnt;
  end

  task automatic test_reset();
    rst = 1'b1; req = 4'b1111; lock = '0;
    step(); step();
    total++; if (gnt !== 4'b0000) begin bad++; $display("FAIL reset_gnt got=%b exp=0000", gnt); end
    total++; if (owner !== 3'd0) begin bad++; $display("FAIL reset_owner got=%0d exp=0", owner); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if (timeout !== 1'b0) begin bad++; $display("FAIL reset_timeout got=%b exp=0", timeout); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", err); end
    rst = 1'b0;
    step();
    total++; if (gnt !== 4'b0001) begin bad++; $display("FAIL reset_first_gnt got=%b exp=0001", gnt); end
    total++; if (owner !== 3'd0) begin bad++; $display("FAIL reset_first_owner got=%0d exp=0", owner); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL reset_first_busy got=%b exp=1", busy); end
  endtask

  task automatic test_single();
    do_reset();
    req = 4'b0100;
    for (int i = 0; i < 20; i++) begin
      step();
      total++; if (gnt !== 4'b0100) begin bad++; $display("FAIL single_gnt cyc=%0d got=%b exp=0100", i, gnt); end
      total++; if (owner !== 3'd2) begin bad++; $display("FAIL single_owner cyc=%0d got=%0d exp=2", i, owner); end
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL single_busy cyc=%0d got=%b exp=1", i, busy); end
    end
    req = 4'b0000;
    step();
    total++; if (gnt !== 4'b0000) begin bad++; $display("FAIL single_drop got=%b exp=0000", gnt); end
    step();
    total++; if (gnt !== 4'b0000 || busy !== 1'b0) begin bad++; $display("FAIL single_idle gnt=%b busy=%b exp=0000/0", gnt, busy); end
  endtask

  task automatic test_contention();
    logic [3:0] exp_g [21];
    logic [2:0] exp_o;
    exp_g = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0000,
              4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0000,
              4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0000,
              4'b1000, 4'b1000, 4'b1000, 4'b1000, 4'b0000,
              4'b0001};
    do_reset();
    req = 4'b1111;
    for (int i = 0; i < 21; i++) begin
      step();
      case (exp_g[i])
        4'b0010: exp_o = 3'd1;
        4'b0100: exp_o = 3'd2;
        4'b1000: exp_o = 3'd3;
        default: exp_o = 3'd0;
      endcase
      total++; if (gnt !== exp_g[i]) begin bad++; $display("FAIL contend_gnt cyc=%0d got=%b exp=%b", i, gnt, exp_g[i]); end
      total++; if (owner !== exp_o) begin bad++; $display("FAIL contend_owner cyc=%0d got=%0d exp=%0d", i, owner, exp_o); end
      total++; if (timeout !== 1'b0) begin bad++; $display("FAIL contend_timeout cyc=%0d got=%b exp=0", i, timeout); end
    end
  endtask

  task automatic test_lock_timeout();
    do_reset();
    req = 4'b0011; lock = 4'b0001;
    for (int i = 0; i < 16; i++) begin
      step();
      total++; if (gnt !== 4'b0001) begin bad++; $display("FAIL lock_gnt cyc=%0d got=%b exp=0001", i, gnt); end
      total++; if (timeout !== 1'b0 || err !== 1'b0) begin bad++; $display("FAIL lock_early_flags cyc=%0d to=%b err=%b exp=0/0", i, timeout, err); end
    end
    step();
    total++; if (gnt !== 4'b0000) begin bad++; $display("FAIL lock_gap_gnt got=%b exp=0000", gnt); end
    total++; if (timeout !== 1'b1) begin bad++; $display("FAIL lock_timeout got=%b exp=1", timeout); end
    total++; if (err !== 1'b1) begin bad++; $display("FAIL lock_err got=%b exp=1", err); end
    step();
    total++; if (gnt !== 4'b0010 || owner !== 3'd1) begin bad++; $display("FAIL lock_next gnt=%b owner=%0d exp=0010/1", gnt, owner); end
    total++; if (timeout !== 1'b0) begin bad++; $display("FAIL lock_pulse got=%b exp=0", timeout); end
    lock = 4'b0000; req = 4'b0000;
    step(); step();
    total++; if (err !== 1'b1) begin bad++; $display("FAIL lock_err_sticky got=%b exp=1", err); end
  endtask

  task automatic test_early_release();
    do_reset();
    req = 4'b1100;
    step();
    total++; if (gnt !== 4'b0100) begin bad++; $display("FAIL early_first got=%b exp=0100", gnt); end
    step();
    total++; if (gnt !== 4'b0100) begin bad++; $display("FAIL early_second got=%b exp=0100", gnt); end
    req = 4'b1000;
    step();
    total++; if (gnt !== 4'b0000) begin bad++; $display("FAIL early_gap got=%b exp=0000", gnt); end
    step();
    total++; if (gnt !== 4'b1000 || owner !== 3'd3) begin bad++; $display("FAIL early_next gnt=%b owner=%0d exp=1000/3", gnt, owner); end
  endtask

  task automatic test_reset_mid_grant();
    do_reset();
    req = 4'b0011; lock = 4'b0001;
    for (int i = 0; i < 18; i++) step();
    total++; if (gnt !== 4'b0010 || err !== 1'b1) begin bad++; $display("FAIL midrst_setup gnt=%b err=%b exp=0010/1", gnt, err); end
    rst = 1'b1; req = 4'b1111; lock = 4'b0000;
    step();
    total++; if (gnt !== 4'b0000) begin bad++; $display("FAIL midrst_gnt got=%b exp=0000", gnt); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL midrst_err got=%b exp=0", err); end
    total++; if (owner !== 3'd0 || busy !== 1'b0) begin bad++; $display("FAIL midrst_owner owner=%0d busy=%b exp=0/0", owner, busy); end
    rst = 1'b0;
    step();
    total++; if (gnt !== 4'b0001) begin bad++; $display("FAIL midrst_first got=%b exp=0001", gnt); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_lock_timeout();
    test_early_release();
    test_reset_mid_grant();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bus_arbiter.md
# bus_arbiter

- Round-robin arbiter for the shared 16-bit tiny16 bus, so that more than one master can drive it in turn.
- Masters are the controller, keyboard capture and display refresh, plus a spare.
- Each master raises a request; the arbiter returns a registered one-hot grant that gates that master's `*_out_en`.
- Every change of owner is separated by a one-cycle dead gap, so two drivers never overlap. Bounded hold time keeps masters from being starved; a bounded lock covers indivisible sequences.
- Sits beside `bus`, runs on `clk_1mhz`.

## Interface
- `NREQ`, default 4: number of requesters (2..8).
- `MAX_HOLD`, default 4: maximum consecutive grant cycles for an unlocked owner while another request is pending.
- `LOCK_LIMIT`, default 16: maximum consecutive grant cycles for a locked owner. Must be greater than `MAX_HOLD`.

Clock and reset: one clock; reset is synchronous and active-high.

- `clk`  in  1  system clock (`clk_1mhz`).
- `rst`  in  1  synchronous, active-high reset.
- `req`  in  NREQ  per-requester bus request, level.
- `lock`  in  NREQ  per-requester lock; meaningful only for the current owner.
- `gnt`  out  NREQ  registered one-hot grant; all zero when the bus is free or in the gap cycle.
- `owner`  out  3  index of the granted requester; 0 when `gnt` is zero.
- `busy`  out  1  OR of all `gnt` bits.
- `timeout`  out  1  one-cycle pulse when a lock is force-released.
- `err`  out  1  sticky lock-timeout flag; cleared only by `rst`.

## Operation
- States:
  - IDLE: no grant.
  - GRANT: one owner holds the bus.
  - GAP: one dead cycle with `gnt` all zero.
- Arbitration runs in IDLE and GAP using `req` sampled that cycle.
  - Search order is `last+1, last+2, …, last`, modulo NREQ.
  - `last` is the most recent owner; it resets to NREQ-1, so requester 0 wins first.
  - Winner found: go to GRANT, load `gnt`, `owner` and `last`, clear `hold_cnt`.
  - No winner: go to (or stay in) IDLE.
- `hold_cnt` is the number of completed grant cycles; it is 0 in the first GRANT cycle. `other` means any `req` bit other than the owner's is high.
- Leaving GRANT, evaluated in priority order at each GRANT clock edge:
  1. `req[owner]` low: go to GAP.
  2. `lock[owner]` high and `hold_cnt == LOCK_LIMIT-1`: go to GAP, set `timeout`=1 for the GAP cycle, set `err`.
  3. `lock[owner]` low, `hold_cnt >= MAX_HOLD-1` and `other`: go to GAP (preemption).
  4. Otherwise: stay in GRANT; increment `hold_cnt`.
- `hold_cnt` saturation:
  - While unlocked it saturates at MAX_HOLD-1.
  - When locked it counts on toward LOCK_LIMIT-1, even if the lock is asserted late in the tenure.
- An uncontended, unlocked owner keeps the bus indefinitely.
- Width: `hold_cnt` is `$clog2(LOCK_LIMIT)` bits. The `req`/`lock` bits of non-owners are ignored in GRANT.
- A request raised in the same cycle the owner drops is served after the GAP cycle.
- A requester whose request is still high after a forced release competes again, but at lowest round-robin priority.

## Timing
- Reset values: `gnt`=0, `owner`=0, `busy`=0, `timeout`=0, `err`=0, state IDLE, `last`=NREQ-1, `hold_cnt`=0.
- `rst` sampled high at an edge gives the reset values after that edge, including mid-GRANT. The owner must treat the loss of `gnt` as an abort.
- Request latency from IDLE: `req` high in cycle n gives `gnt` in cycle n+1.
- Handover: the owner's `req` low in cycle n gives `gnt`=0 in n+1 (GAP) and the next owner's `gnt` in n+2.
- A contended unlocked owner holds `gnt` for exactly MAX_HOLD cycles.
- A locked owner holds `gnt` for at most LOCK_LIMIT cycles.
- `gnt` is never non-zero in two consecutive cycles for different owners.
- `gnt` is never multi-hot.
- All outputs are registered; there are no combinational paths from input to output.

## Test plan
All scenarios use NREQ=4, MAX_HOLD=4, LOCK_LIMIT=16.

- **Reset:** `rst`=1 for 2 cycles with `req`=1111 → all outputs 0. `rst` falls at edge e → `gnt`=0001, `owner`=0 after edge e+1.
- **Single requester:** `req`=0100 for 20 cycles → `gnt`=0100 from the cycle after `req` rises, `busy`=1, `owner`=2 throughout. `req` drops → `gnt`=0 next cycle, state IDLE.
- **Full contention:** `req`=1111 held → `gnt` sequence 0001×4, 0, 0010×4, 0, 0100×4, 0, 1000×4, 0, then 0001 again.
- **Lock timeout:** `req`=0011, `lock`=0001 → `gnt`=0001 for 16 cycles, then 0 with `timeout`=1 for one cycle and `err`=1 sticky, then `gnt`=0010.
- **Early release:** owner 2 drops `req` after 2 grant cycles while `req[3]`=1 → one gap cycle, then `gnt`=1000, `owner`=3.
- **Reset mid-grant:** `rst` pulsed while `gnt`=0010 and `err`=1 → `gnt`=0 and `err`=0 after the edge. With `req`=1111 afterwards, the first grant goes to 0001.
